// File: rtl/cp0_timer_unit_if.sv
// Pipeline <-> CP0 bus: mfc0/mtc0 access, M-stage exception inputs,
// interrupt lines and the request/redirect outputs back to the pipeline.
`timescale 1ns/1ps
interface cp0_timer_unit_if #(
    parameter int HW_INTS = 6
);
    logic [4:0]         sel;
    logic [31:0]        rdata;
    logic               we;
    logic [31:0]        wdata;
    logic [31:0]        vpc;
    logic               bd_in;
    logic [4:0]         exc_code_in;
    logic [31:0]        bad_vaddr_in;
    logic [HW_INTS-1:0] hw_int;
    logic               eret;
    logic [31:0]        epc_out;
    logic [1:0]         req;
    logic               exl_out;
    logic               timer_irq;

    // Pipeline side
    modport master (
        output sel, we, wdata, vpc, bd_in, exc_code_in, bad_vaddr_in, hw_int, eret,
        input  rdata, epc_out, req, exl_out, timer_irq
    );

    // Coprocessor side
    modport slave (
        input  sel, we, wdata, vpc, bd_in, exc_code_in, bad_vaddr_in, hw_int, eret,
        output rdata, epc_out, req, exl_out, timer_irq
    );
endinterface

// File: rtl/cp0_timer_unit.sv
// Coprocessor 0: SR/Cause/EPC/BadVAddr/Count/Compare/PRId, interrupt and
// exception entry arbitration, eret handling and an optional Count/Compare timer.
`timescale 1ns/1ps
module cp0_timer_unit #(
    parameter int          HW_INTS    = 6,
    parameter int          TIMER_EN   = 1,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] PRID       = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             reset,
    cp0_timer_unit_if.slave  bus
);
    localparam logic [4:0] SEL_BADVADDR = 5'd8;
    localparam logic [4:0] SEL_COUNT    = 5'd9;
    localparam logic [4:0] SEL_COMPARE  = 5'd11;
    localparam logic [4:0] SEL_SR       = 5'd12;
    localparam logic [4:0] SEL_CAUSE    = 5'd13;
    localparam logic [4:0] SEL_EPC      = 5'd14;
    localparam logic [4:0] SEL_PRID     = 5'd15;

    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ti_q;

    logic [5:0]  ip_hw;
    logic [7:0]  ip;
    logic        interrupt_req;
    logic        exception_req;
    logic        entry;
    logic        wr_en;

    // Hardware IP bits: external lines where present, timer ORed onto its line
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ip
            logic line;
            if (gi < HW_INTS) begin : g_line
                assign line = bus.hw_int[gi];
            end else begin : g_noline
                assign line = 1'b0;
            end
            if (gi == TIMER_LINE) begin : g_ti
                assign ip_hw[gi] = line | ti_q;
            end else begin : g_noti
                assign ip_hw[gi] = line;
            end
        end
    endgenerate

    assign ip            = {ip_hw, ip_sw_q};
    assign interrupt_req = ie_q & ~exl_q & (|(im_q & ip));
    assign exception_req = ~exl_q & (bus.exc_code_in != 5'd0);
    assign entry         = interrupt_req | exception_req;
    // An mtc0 in the same cycle as entry is flushed with its instruction
    assign wr_en         = bus.we & ~entry;

    // Status/cause/EPC/BadVAddr state: reset, then entry, then eret/mtc0
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else if (entry) begin
            exl_q      <= 1'b1;
            bd_q       <= bus.bd_in;
            epc_q      <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
            exc_code_q <= interrupt_req ? 5'd0 : bus.exc_code_in;
            if (!interrupt_req && (bus.exc_code_in == 5'd4 || bus.exc_code_in == 5'd5))
                badvaddr_q <= bus.bad_vaddr_in;
        end else begin
            if (wr_en && bus.sel == SEL_SR) begin
                im_q  <= bus.wdata[15:8];
                exl_q <= bus.wdata[1];
                ie_q  <= bus.wdata[0];
            end
            if (wr_en && bus.sel == SEL_CAUSE)
                ip_sw_q <= bus.wdata[9:8];
            if (wr_en && bus.sel == SEL_EPC)
                epc_q <= {bus.wdata[31:2], 2'b00};
            // eret wins over any EXL value written in the same cycle
            if (bus.eret)
                exl_q <= 1'b0;
        end
    end

    generate
        if (TIMER_EN != 0) begin : g_timer
            // Free-running Count, Compare and sticky TI (Compare write clears)
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_q   <= 32'd0;
                    compare_q <= 32'hFFFF_FFFF;
                    ti_q      <= 1'b0;
                end else begin
                    if (wr_en && bus.sel == SEL_COUNT)
                        count_q <= bus.wdata;
                    else
                        count_q <= count_q + 32'd1;
                    if (wr_en && bus.sel == SEL_COMPARE) begin
                        compare_q <= bus.wdata;
                        ti_q      <= 1'b0;
                    end else if (count_q == compare_q) begin
                        ti_q <= 1'b1;
                    end
                end
            end
        end else begin : g_no_timer
            assign count_q   = 32'd0;
            assign compare_q = 32'd0;
            assign ti_q      = 1'b0;
        end
    endgenerate

    // Read mux reflects pre-edge state; Cause shows the live IP bits
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.sel)
            SEL_SR:       bus.rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
            SEL_CAUSE:    bus.rdata = {bd_q, ti_q, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
            SEL_EPC:      bus.rdata = epc_q;
            SEL_BADVADDR: bus.rdata = badvaddr_q;
            SEL_COUNT:    bus.rdata = count_q;
            SEL_COMPARE:  bus.rdata = compare_q;
            SEL_PRID:     bus.rdata = PRID;
            default:      bus.rdata = 32'd0;
        endcase
    end

    assign bus.epc_out   = epc_q;
    assign bus.req       = {exception_req, interrupt_req};
    assign bus.exl_out   = exl_q;
    assign bus.timer_irq = ti_q;

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Directed bench for cp0_timer_unit with an expected-value queue.
`timescale 1ns/1ps
module tb_cp0_timer_unit;
    logic clk;
    logic reset;

    cp0_timer_unit_if #(.HW_INTS(6)) bus ();

    cp0_timer_unit #(
        .HW_INTS(6), .TIMER_EN(1), .TIMER_LINE(5), .PRID(32'h0000_0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
            $display("check %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic rd(input logic [4:0] s, input string tag, input logic [31:0] v);
        bus.sel = s;
        expect_val(tag, v);
        #1;
        check(bus.rdata);
    endtask

    task automatic sig(input string tag, input logic [31:0] obs, input logic [31:0] v);
        expect_val(tag, v);
        check(obs);
    endtask

    task automatic wr(input logic [4:0] s, input logic [31:0] d);
        bus.sel   = s;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    initial begin
        bus.sel = 5'd0; bus.we = 1'b0; bus.wdata = 32'd0; bus.vpc = 32'd0;
        bus.bd_in = 1'b0; bus.exc_code_in = 5'd0; bus.bad_vaddr_in = 32'd0;
        bus.hw_int = 6'd0; bus.eret = 1'b0;
        reset = 1'b1;
        tick();
        tick();

        // Reset values (reset held so Count stays at 0 during the sweep)
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = 32'd0;
            if (i == 11) v = 32'hFFFF_FFFF;
            if (i == 15) v = 32'h0000_0001;
            rd(i[4:0], $sformatf("reset_sel%0d", i), v);
        end
        sig("reset_req", {30'd0, bus.req}, 32'd0);
        sig("reset_exl", {31'd0, bus.exl_out}, 32'd0);
        sig("reset_ti", {31'd0, bus.timer_irq}, 32'd0);
        sig("reset_epc", bus.epc_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Hardware interrupt entry from a delay slot
        wr(5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3010; bus.bd_in = 1'b1;
        #1;
        sig("hwint_req", {30'd0, bus.req}, 32'd1);
        tick();
        sig("hwint_exl", {31'd0, bus.exl_out}, 32'd1);
        rd(5'd13, "hwint_cause", 32'h8000_0400);
        rd(5'd14, "hwint_epc", 32'h0000_300C);
        sig("hwint_epc_out", bus.epc_out, 32'h0000_300C);
        sig("hwint_req_exl", {30'd0, bus.req}, 32'd0);
        bus.hw_int = 6'd0; bus.bd_in = 1'b0; bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        sig("eret_exl", {31'd0, bus.exl_out}, 32'd0);
        rd(5'd12, "eret_sr", 32'h0000_0401);

        // AdEL captures BadVAddr
        bus.exc_code_in = 5'd4; bus.bad_vaddr_in = 32'h0000_0003; bus.vpc = 32'h0000_3000;
        #1;
        sig("adel_req", {30'd0, bus.req}, 32'd2);
        tick();
        bus.exc_code_in = 5'd0;
        rd(5'd13, "adel_cause", 32'h0000_0010);
        rd(5'd8, "adel_badvaddr", 32'h0000_0003);
        rd(5'd14, "adel_epc", 32'h0000_3000);
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;

        // Other exception code leaves BadVAddr alone
        bus.exc_code_in = 5'd10; bus.bad_vaddr_in = 32'h0000_DEAD; bus.vpc = 32'h0000_3100;
        tick();
        bus.exc_code_in = 5'd0;
        rd(5'd13, "exc10_cause", 32'h0000_0028);
        rd(5'd8, "exc10_badvaddr", 32'h0000_0003);
        rd(5'd14, "exc10_epc", 32'h0000_3100);
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;

        // Interrupt + exception + EPC write in one cycle
        bus.hw_int = 6'b000001; bus.exc_code_in = 5'd12; bus.vpc = 32'h0000_3200;
        #1;
        sig("both_req", {30'd0, bus.req}, 32'd3);
        wr(5'd14, 32'h0000_5550);
        bus.hw_int = 6'd0; bus.exc_code_in = 5'd0;
        rd(5'd13, "both_cause", 32'h0000_0000);
        rd(5'd14, "entry_epc_write_lost", 32'h0000_3200);

        // eret with SR write of EXL|IE
        bus.eret = 1'b1;
        wr(5'd12, 32'h0000_0003);
        bus.eret = 1'b0;
        rd(5'd12, "eret_wr_sr", 32'h0000_0001);
        sig("eret_wr_exl", {31'd0, bus.exl_out}, 32'd0);

        // Masking and software interrupts
        wr(5'd12, 32'h0000_0400);
        bus.hw_int = 6'b000001;
        #1;
        sig("ie0_req", {30'd0, bus.req}, 32'd0);
        bus.hw_int = 6'd0;
        wr(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, "cause_sw_only", 32'h0000_0300);
        wr(5'd12, 32'h0000_0101);
        #1;
        sig("swint_req", {30'd0, bus.req}, 32'd1);
        bus.vpc = 32'h0000_3400;
        tick();
        sig("swint_exl", {31'd0, bus.exl_out}, 32'd1);
        rd(5'd14, "swint_epc", 32'h0000_3400);
        wr(5'd13, 32'h0000_0000);
        wr(5'd12, 32'h0000_0000);
        rd(5'd12, "sr_cleared", 32'h0000_0000);
        wr(5'd14, 32'h0000_3007);
        rd(5'd14, "epc_align", 32'h0000_3004);

        // Count/Compare timer
        wr(5'd12, 32'h0000_8001);
        wr(5'd9, 32'h0000_0000);
        rd(5'd9, "count_loaded", 32'h0000_0000);
        wr(5'd11, 32'h0000_0005);
        rd(5'd9, "count_run", 32'h0000_0001);
        rd(5'd11, "compare_wr", 32'h0000_0005);
        for (int i = 0; i < 4; i++) tick();
        sig("ti_before", {31'd0, bus.timer_irq}, 32'd0);
        sig("ti_req_before", {30'd0, bus.req}, 32'd0);
        tick();
        sig("ti_set", {31'd0, bus.timer_irq}, 32'd1);
        rd(5'd13, "ti_cause", 32'h4000_8000);
        sig("ti_req", {30'd0, bus.req}, 32'd1);
        tick();
        sig("ti_entry_exl", {31'd0, bus.exl_out}, 32'd1);
        sig("ti_kept", {31'd0, bus.timer_irq}, 32'd1);
        wr(5'd11, 32'h1000_0000);
        sig("ti_cleared", {31'd0, bus.timer_irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
